// File: rtl/mmio_uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : mmio_uart_tx_if
// Brief    : Processor data-memory bus slice seen by the memory-mapped UART TX.
// Revision : 1.0 - initial release
// ============================================================================
interface mmio_uart_tx_if;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    logic        sel;

    modport master (
        output addr,
        output wdata,
        output we,
        input  rdata,
        input  sel
    );

    modport slave (
        input  addr,
        input  wdata,
        input  we,
        output rdata,
        output sel
    );
endinterface
`default_nettype wire

// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : mmio_uart_tx
// Brief    : Memory-mapped UART transmitter (window 0xC0-0xC7) with TX FIFO
//            and STATUS register. Define UART_PARITY_EN for 8E1 framing.
// Revision : 1.0 - initial release
// ============================================================================
module mmio_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic               clk,
    input  logic               rst,
    mmio_uart_tx_if.slave      bus,
    output logic               tx
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [BAUD_W-1:0] C_BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  C_FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [4:0]        C_WINDOW     = 5'b11000;

`ifdef UART_PARITY_EN
    localparam logic C_PARITY_FLAG = 1'b1;
`else
    localparam logic C_PARITY_FLAG = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t            r_state;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;
    logic              r_tx;
`ifdef UART_PARITY_EN
    logic              r_parity;
`endif

    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_ovf;

    logic              w_sel;
    logic              w_wr_txdata;
    logic              w_wr_status;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_baud_done;
    logic              w_active;
    logic [7:0]        w_head;
    logic [3:0]        w_count4;
    logic [31:0]       w_status;
    logic              w_unused_bits;

    // ------------------------------------------------------------------
    // Address decode and FIFO status
    // ------------------------------------------------------------------
    assign w_sel       = (bus.addr[7:3] == C_WINDOW);
    assign w_wr_txdata = bus.we && w_sel && !bus.addr[2];
    assign w_wr_status = bus.we && w_sel &&  bus.addr[2];

    assign w_full      = (r_count == C_FULL_COUNT);
    assign w_empty     = (r_count == '0);
    // full is judged on the pre-edge count, so a same-edge pop never frees a slot
    assign w_push      = w_wr_txdata && !w_full;

    assign w_baud_done = (r_baud == C_BAUD_LAST);
    assign w_pop       = !w_empty &&
                         ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_done));
    assign w_head      = r_mem[r_rptr];
    assign w_active    = (r_state != S_IDLE);

    assign w_unused_bits = &{1'b0, bus.wdata[31:8], bus.addr[1:0]};

    // ------------------------------------------------------------------
    // Transmit FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= bus.wdata[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase

            if (w_wr_txdata && w_full) begin
                r_ovf <= 1'b1;
            end else if (w_wr_status && bus.wdata[3]) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Serializer FSM; r_tx always carries the level of the state being
    // entered so the line never depends combinationally on the bus.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
`ifdef UART_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_baud <= '0;
                    r_tx   <= 1'b1;
                    if (w_pop) begin
                        r_shift <= w_head;
`ifdef UART_PARITY_EN
                        r_parity <= ^w_head;
`endif
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end
                end

                S_START: begin
                    if (w_baud_done) begin
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                        r_tx      <= r_shift[0];
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_state   <= S_DATA;
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end

                S_DATA: begin
                    if (w_baud_done) begin
                        r_baud <= '0;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                            r_tx    <= r_parity;
                            r_state <= S_PARITY;
`else
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[7:1]};
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end

                S_PARITY: begin
                    if (w_baud_done) begin
                        r_baud  <= '0;
                        r_tx    <= 1'b1;
                        r_state <= S_STOP;
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end

                S_STOP: begin
                    if (w_baud_done) begin
                        r_baud <= '0;
                        // chain straight into the next start bit when more data waits
                        if (w_pop) begin
                            r_shift <= w_head;
`ifdef UART_PARITY_EN
                            r_parity <= ^w_head;
`endif
                            r_tx    <= 1'b0;
                            r_state <= S_START;
                        end else begin
                            r_tx    <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end

                default: begin
                    r_baud  <= '0;
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign tx = r_tx;

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    assign w_count4 = 4'(r_count);
    assign w_status = {20'd0, w_count4, 3'd0, C_PARITY_FLAG, r_ovf, w_active, w_empty, w_full};

    assign bus.sel   = w_sel;
    assign bus.rdata = (w_sel && bus.addr[2]) ? w_status : 32'd0;

endmodule
`default_nettype wire
